lakespec_cfg_sequencer: RTL and testbench

Bring-up controller for the `lakespec` memory tile. It loads the flat `config_memory` vector from a narrow valid/ready word stream, holds the tile in reset while configuration settles, and runs a fixed flush window. It then releases the tile to run. It sits between the host/global configuration bus and one `lakespec` instance, and drives the tile's `config_memory`, `rst_n` and `flush` pins.

---
 rtl/lake_cfg_pkg.sv | 29 ++
 rtl/lake_phase_timer.sv | 28 ++
 rtl/lakespec_cfg_sequencer.sv | 129 ++++++++++++
 tb/tb_lakespec_cfg_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lake_cfg_pkg.sv
// Shared types and sizing helpers for the lakespec configuration sequencer.
// Widths are derived here so the top and the phase timer agree on them.
package lake_cfg_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } cfg_seq_state_t;

    function automatic int cfg_num_words(input int size, input int width);
        return (size + width - 1) / width;
    endfunction

    function automatic int cfg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // word_cnt must be able to hold NUM_WORDS itself.
    function automatic int cfg_cnt_width(input int num_words);
        return $clog2(num_words + 1);
    endfunction

    function automatic int cfg_tmr_width(input int rst_cycles, input int flush_cycles);
        return $clog2(cfg_max(rst_cycles, flush_cycles) + 1);
    endfunction

endpackage

// File: rtl/lake_phase_timer.sv
// Loadable down-counter shared by the HOLD and FLUSH phases.
// expired is high during the last cycle of a loaded window.
module lake_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // A window loaded with N spans N cycles; the final one has count==1.
    assign expired = (count == W'(1));

endmodule

// File: rtl/lakespec_cfg_sequencer.sv
// Bring-up controller for one lakespec tile: streams in config_memory, holds
// the tile in reset, runs a flush window, then releases the tile to RUN.
module lakespec_cfg_sequencer
    import lake_cfg_pkg::*;
#(
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int CFG_WORD_WIDTH     = 32,
    parameter int RST_CYCLES         = 2,
    parameter int FLUSH_CYCLES       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CFG_WORD_WIDTH-1:0]     cfg_data,
    input  logic                          cfg_last,
    input  logic                          reconfig,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          dut_rst_n,
    output logic                          flush,
    output logic                          running,
    output logic                          len_err
);

    localparam int NUM_WORDS = cfg_num_words(CONFIG_MEMORY_SIZE, CFG_WORD_WIDTH);
    localparam int CNT_W     = cfg_cnt_width(NUM_WORDS);
    localparam int TMR_W     = cfg_tmr_width(RST_CYCLES, FLUSH_CYCLES);

    cfg_seq_state_t   state;
    logic [CNT_W-1:0] word_cnt;
    logic             hs;
    logic             last_word;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_expired;

    // Valid/ready: a word transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; ready depends only on state, never on valid.
    assign cfg_ready = (state == LOAD);
    assign hs        = cfg_valid & cfg_ready;
    assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

    // HOLD is armed by the final word, FLUSH by HOLD expiring.
    assign tmr_load  = (hs && last_word) || ((state == HOLD) && tmr_expired);
    assign tmr_value = (state == LOAD) ? TMR_W'(RST_CYCLES) : TMR_W'(FLUSH_CYCLES);

    lake_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    // One slice per word; the top slice is truncated when the size is not a
    // whole number of words, so the excess data bits are simply not stored.
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        localparam int LO = w * CFG_WORD_WIDTH;
        localparam int HI = (((w + 1) * CFG_WORD_WIDTH) < CONFIG_MEMORY_SIZE) ?
                            ((w + 1) * CFG_WORD_WIDTH) - 1 : CONFIG_MEMORY_SIZE - 1;

        logic word_we;
        assign word_we = hs && (word_cnt == CNT_W'(w));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                config_memory[HI:LO] <= '0;
            end else if (word_we) begin
                config_memory[HI:LO] <= cfg_data[HI-LO:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            word_cnt  <= '0;
            dut_rst_n <= 1'b0;
            flush     <= 1'b0;
            running   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (hs) begin
                        if (last_word) begin
                            state    <= HOLD;
                            word_cnt <= '0;
                            if (!cfg_last) len_err <= 1'b1;
                        end else if (cfg_last) begin
                            // Short stream: restart, keep stale words until overwritten.
                            word_cnt <= '0;
                            len_err  <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (tmr_expired) begin
                        state     <= FLUSH;
                        dut_rst_n <= 1'b1;
                        flush     <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (tmr_expired) begin
                        state   <= RUN;
                        flush   <= 1'b0;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (reconfig) begin
                        state     <= LOAD;
                        word_cnt  <= '0;
                        running   <= 1'b0;
                        dut_rst_n <= 1'b0;
                        len_err   <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lakespec_cfg_sequencer.sv
// Directed bench for lakespec_cfg_sequencer: default 512-bit instance plus a
// 40-bit instance for the truncated last word.
module tb_lakespec_cfg_sequencer;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [31:0]  cfg_data;
    logic         cfg_last;
    logic         reconfig;
    logic [511:0] config_memory;
    logic         dut_rst_n;
    logic         flush;
    logic         running;
    logic         len_err;

    logic         o_valid;
    logic         o_ready;
    logic [31:0]  o_data;
    logic         o_last;
    logic         o_reconfig;
    logic [39:0]  o_mem;
    logic         o_rst_n;
    logic         o_flush;
    logic         o_running;
    logic         o_len_err;

    int n_checks = 0;
    int n_fail   = 0;

    lakespec_cfg_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .reconfig      (reconfig),
        .config_memory (config_memory),
        .dut_rst_n     (dut_rst_n),
        .flush         (flush),
        .running       (running),
        .len_err       (len_err)
    );

    lakespec_cfg_sequencer #(
        .CONFIG_MEMORY_SIZE (40),
        .CFG_WORD_WIDTH     (32),
        .RST_CYCLES         (2),
        .FLUSH_CYCLES       (4)
    ) dut_odd (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (o_valid),
        .cfg_ready     (o_ready),
        .cfg_data      (o_data),
        .cfg_last      (o_last),
        .reconfig      (o_reconfig),
        .config_memory (o_mem),
        .dut_rst_n     (o_rst_n),
        .flush         (o_flush),
        .running       (o_running),
        .len_err       (o_len_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Back-to-back word driver; returns 1 time unit after the last accepting edge.
    task automatic send_stream(input logic [31:0] base, input int n, input int last_idx);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = base + k;
            cfg_last  = (k == last_idx);
            @(posedge clk);
        end
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic pulse_reconfig();
        @(negedge clk);
        reconfig = 1'b1;
        @(negedge clk);
        reconfig = 1'b0;
    endtask

    task automatic test_reset();
        send_stream(32'h0BAD_0000, 3, -1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (config_memory !== 512'd0) begin n_fail++; $display("FAIL reset_mem: got %h required 0", config_memory[63:0]); end
        n_checks++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_rst_n: got %b required 0", dut_rst_n); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b required 0", flush); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b required 0", running); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b required 0", len_err); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        logic [31:0] exp_w;
        send_stream(32'h1000_0000, 16, 15);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_checks++; if (dut_rst_n !== (c >= 3)) begin n_fail++; $display("FAIL nom_rst_n c=%0d: got %b required %b", c, dut_rst_n, (c >= 3)); end
            n_checks++; if (flush !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL nom_flush c=%0d: got %b required %b", c, flush, (c >= 3 && c <= 6)); end
            n_checks++; if (running !== (c >= 7)) begin n_fail++; $display("FAIL nom_running c=%0d: got %b required %b", c, running, (c >= 7)); end
            n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL nom_ready c=%0d: got %b required 0", c, cfg_ready); end
        end
        for (int k = 0; k < 16; k++) begin
            exp_w = 32'h1000_0000 + k;
            n_checks++; if (config_memory[k*32 +: 32] !== exp_w) begin n_fail++; $display("FAIL nom_slice%0d: got %h required %h", k, config_memory[k*32 +: 32], exp_w); end
        end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL nom_len_err: got %b required 0", len_err); end
    endtask

    task automatic test_early_last();
        logic [31:0] exp_w;
        pulse_reconfig();
        send_stream(32'h2000_0000, 6, 5);
        @(negedge clk);
        n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL early_len_err: got %b required 1", len_err); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL early_ready: got %b required 1", cfg_ready); end
        n_checks++; if (config_memory[5*32 +: 32] !== 32'h2000_0005) begin n_fail++; $display("FAIL early_slice5: got %h required 20000005", config_memory[5*32 +: 32]); end
        send_stream(32'h3000_0000, 16, 15);
        repeat (7) @(negedge clk);
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL early_running: got %b required 1", running); end
        n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL early_len_err_sticky: got %b required 1", len_err); end
        for (int k = 0; k < 16; k++) begin
            exp_w = 32'h3000_0000 + k;
            n_checks++; if (config_memory[k*32 +: 32] !== exp_w) begin n_fail++; $display("FAIL early_slice%0d: got %h required %h", k, config_memory[k*32 +: 32], exp_w); end
        end
    endtask

    task automatic test_reconfig();
        pulse_reconfig();
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL rcfg_running: got %b required 0", running); end
        n_checks++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL rcfg_rst_n: got %b required 0", dut_rst_n); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rcfg_ready: got %b required 1", cfg_ready); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL rcfg_len_err: got %b required 0", len_err); end
        n_checks++; if (config_memory[3*32 +: 32] !== 32'h3000_0003) begin n_fail++; $display("FAIL rcfg_retained: got %h required 30000003", config_memory[3*32 +: 32]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w;
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            cfg_valid = ($urandom_range(0, 1) == 1);
            cfg_data  = cfg_valid ? (32'h4000_0000 + k) : (32'hBAD0_0000 + cyc);
            cfg_last  = cfg_valid && (k == 15);
            n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_load k=%0d: got %b required 1", k, cfg_ready); end
            @(posedge clk);
            if (cfg_valid) k++;
        end
        n_checks++; if (k != 16) begin n_fail++; $display("FAIL bp_timeout: got %0d words required 16", k); end
        #1;
        cfg_valid = 1'b1;
        cfg_last  = 1'b1;
        cfg_data  = 32'hDEAD_BEEF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_busy c=%0d: got %b required 0", c, cfg_ready); end
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        @(negedge clk);
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL bp_running: got %b required 1", running); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL bp_len_err: got %b required 0", len_err); end
        for (int j = 0; j < 16; j++) begin
            exp_w = 32'h4000_0000 + j;
            n_checks++; if (config_memory[j*32 +: 32] !== exp_w) begin n_fail++; $display("FAIL bp_slice%0d: got %h required %h", j, config_memory[j*32 +: 32], exp_w); end
        end
    endtask

    task automatic test_flush_events();
        pulse_reconfig();
        send_stream(32'h5000_0000, 16, 15);
        repeat (3) @(negedge clk);
        reconfig = 1'b1;
        @(negedge clk);
        reconfig = 1'b0;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL fl_rcfg_flush: got %b required 1", flush); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL fl_rcfg_ready: got %b required 0", cfg_ready); end
        n_checks++; if (dut_rst_n !== 1'b1) begin n_fail++; $display("FAIL fl_rcfg_rst_n: got %b required 1", dut_rst_n); end
        repeat (3) @(negedge clk);
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL fl_rcfg_running: got %b required 1", running); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fl_rcfg_flush_end: got %b required 0", flush); end

        pulse_reconfig();
        send_stream(32'h6000_0000, 16, 15);
        repeat (4) @(negedge clk);
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL fl_rst_pre: got %b required 1", flush); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fl_rst_flush: got %b required 0", flush); end
        n_checks++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL fl_rst_rst_n: got %b required 0", dut_rst_n); end
        n_checks++; if (config_memory !== 512'd0) begin n_fail++; $display("FAIL fl_rst_mem: got %h required 0", config_memory[63:0]); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL fl_rst_ready: got %b required 1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_odd_size();
        @(negedge clk);
        o_valid = 1'b1;
        o_data  = 32'hAAAA_AAAA;
        o_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        o_data  = 32'hFFFF_FFFF;
        o_last  = 1'b1;
        @(posedge clk);
        #1;
        o_valid = 1'b0;
        o_last  = 1'b0;
        @(negedge clk);
        n_checks++; if (o_mem !== 40'hFF_AAAA_AAAA) begin n_fail++; $display("FAIL odd_mem: got %h required ffaaaaaaaa", o_mem); end
        n_checks++; if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL odd_len_err: got %b required 0", o_len_err); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL odd_ready: got %b required 0", o_ready); end
        repeat (6) @(negedge clk);
        n_checks++; if (o_running !== 1'b1) begin n_fail++; $display("FAIL odd_running: got %b required 1", o_running); end
        n_checks++; if (o_rst_n !== 1'b1) begin n_fail++; $display("FAIL odd_rst_n: got %b required 1", o_rst_n); end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        cfg_last   = 1'b0;
        reconfig   = 1'b0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_last     = 1'b0;
        o_reconfig = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_nominal();
        test_early_last();
        test_reconfig();
        test_backpressure();
        test_flush_events();
        test_odd_size();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
